// File: rtl/asic_gpio_ctrl_pkg.sv
`default_nettype none
// gpio_ctrl_pkg: register map, CFG bit indices, reset values and sequencer
// state encoding for the core-side GPIO controller.
package gpio_ctrl_pkg;

  localparam logic [7:0] ADDR_OUT      = 8'h00;
  localparam logic [7:0] ADDR_OEN      = 8'h04;
  localparam logic [7:0] ADDR_IE       = 8'h08;
  localparam logic [7:0] ADDR_IN       = 8'h0C;
  localparam logic [7:0] ADDR_EVT      = 8'h10;
  localparam logic [7:0] ADDR_IRQEN    = 8'h14;
  localparam logic [7:0] ADDR_STATUS   = 8'h18;
  localparam logic [7:0] ADDR_EDGE     = 8'h1C;
  localparam logic [7:0] ADDR_CFG_BASE = 8'h20;

  localparam int CFG_PULL_EN   = 0;
  localparam int CFG_PULL_UP   = 1;
  localparam int CFG_SLEW      = 2;
  localparam int CFG_SCHMITT   = 3;
  localparam int CFG_DRIVE_LSB = 4;
  localparam int CFG_DRIVE_MSB = 7;
  localparam int CFG_W         = CFG_DRIVE_MSB + 1;

  localparam logic [31:0]      RST_OUT   = 32'h0000_0000;
  localparam logic [31:0]      RST_OEN   = 32'hFFFF_FFFF;
  localparam logic [31:0]      RST_IE    = 32'h0000_0000;
  localparam logic [31:0]      RST_IRQEN = 32'h0000_0000;
  localparam logic [31:0]      RST_EDGE  = 32'h0000_0000;
  localparam logic [CFG_W-1:0] RST_CFG   = 8'h00;

  typedef enum logic {
    PWRUP = 1'b0,
    READY = 1'b1
  } seq_state_e;

endpackage : gpio_ctrl_pkg
`default_nettype wire

// File: rtl/asic_gpio_ctrl_sync.sv
`default_nettype none
// gpio_sync: parameterized-width two-flop synchronizer for asynchronous
// pad inputs, async active-low reset to 0.
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : gpio_sync
`default_nettype wire

// File: rtl/asic_gpio_ctrl.sv
`default_nettype none
// asic_gpio_ctrl: register bank driving a row of asic_iobuf pads, with a
// power-up safe-state sequencer and edge-event interrupt on the input path.
module asic_gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int N            = 8,
  parameter int PWRUP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [N-1:0]     pad_dout,
  output logic [N-1:0]     pad_oen,
  output logic [N-1:0]     pad_ie,
  output logic [8*N-1:0]   pad_cfg,
  input  logic [N-1:0]     pad_din,
  output logic             irq
);

  localparam int            CW       = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWRUP_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_ready;

  logic [N-1:0]       out_q, out_d, oen_q, oen_d, ie_q, ie_d;
  logic [N-1:0]       evt_q, evt_d, irqen_q, irqen_d, edge_q, edge_d;
  logic [N-1:0]       hist_q, din_sync;
  logic [CFG_W*N-1:0] cfg_q, cfg_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic [5:0]   w_word, w_cfg_off;
  logic         w_cfg_hit, w_mapped, w_ro, w_accept, w_wr;
  logic [31:0]  w_rd;
  logic [N-1:0] w_wmask, w_evt_set, w_evt_clr, w_pad_ie;
  logic         w_unused;

  // Power-up sequencer: READY is reached on the PWRUP_CYCLES-th edge after reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PWRUP: begin
        if (cnt_q == CNT_LAST) state_d = READY;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = PWRUP;
    endcase
  end

  assign w_ready = (state_q == READY);

  gpio_sync #(.WIDTH(N)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (pad_din),
    .q_o    (din_sync)
  );

  // Address decode and read mux, from register state before this edge.
  always_comb begin
    w_word    = req_addr[7:2];
    w_cfg_off = w_word - ADDR_CFG_BASE[7:2];
    w_cfg_hit = (w_word >= ADDR_CFG_BASE[7:2]) && (w_cfg_off < 6'(N));
    w_rd      = '0;
    w_mapped  = 1'b1;
    w_ro      = 1'b0;
    case ({w_word, 2'b00})
      ADDR_OUT:    w_rd = 32'(out_q);
      ADDR_OEN:    w_rd = 32'(oen_q);
      ADDR_IE:     w_rd = 32'(ie_q);
      ADDR_IN:     begin w_rd = 32'(din_sync); w_ro = 1'b1; end
      ADDR_EVT:    w_rd = 32'(evt_q);
      ADDR_IRQEN:  w_rd = 32'(irqen_q);
      ADDR_STATUS: begin w_rd = {31'd0, w_ready}; w_ro = 1'b1; end
      ADDR_EDGE:   w_rd = 32'(edge_q);
      default: begin
        w_mapped = w_cfg_hit;
        for (int i = 0; i < N; i++) begin
          if (w_cfg_hit && (w_cfg_off == 6'(i))) w_rd = 32'(cfg_q[CFG_W*i +: CFG_W]);
        end
      end
    endcase
  end

  assign w_accept  = req_valid & req_ready;
  assign w_wr      = w_accept & req_write & w_mapped & ~w_ro;
  assign w_wmask   = req_wdata[N-1:0];
  assign w_pad_ie  = w_ready ? ie_q : '0;
  assign w_evt_set = w_pad_ie & ((edge_q & hist_q & ~din_sync) | (~edge_q & ~hist_q & din_sync));
  assign w_evt_clr = (w_wr && ({w_word, 2'b00} == ADDR_EVT)) ? w_wmask : '0;

  always_comb begin
    out_d       = out_q;
    oen_d       = oen_q;
    ie_d        = ie_q;
    irqen_d     = irqen_q;
    edge_d      = edge_q;
    cfg_d       = cfg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    // A hardware set in the same cycle as a W1C keeps the bit set.
    evt_d       = (evt_q & ~w_evt_clr) | w_evt_set;

    if (w_wr) begin
      case ({w_word, 2'b00})
        ADDR_OUT:   out_d   = w_wmask;
        ADDR_OEN:   oen_d   = w_wmask;
        ADDR_IE:    ie_d    = w_wmask;
        ADDR_IRQEN: irqen_d = w_wmask;
        ADDR_EDGE:  edge_d  = w_wmask;
        ADDR_EVT:   ;
        default: begin
          for (int i = 0; i < N; i++) begin
            if (w_cfg_off == 6'(i)) cfg_d[CFG_W*i +: CFG_W] = req_wdata[CFG_W-1:0];
          end
        end
      endcase
    end

    if (w_accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_write ? 32'd0 : w_rd;
      rsp_err_d   = ~w_mapped | (req_write & w_ro);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q       <= RST_OUT[N-1:0];
      oen_q       <= RST_OEN[N-1:0];
      ie_q        <= RST_IE[N-1:0];
      evt_q       <= '0;
      irqen_q     <= RST_IRQEN[N-1:0];
      edge_q      <= RST_EDGE[N-1:0];
      cfg_q       <= {N{RST_CFG}};
      hist_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      oen_q       <= oen_d;
      ie_q        <= ie_d;
      evt_q       <= evt_d;
      irqen_q     <= irqen_d;
      edge_q      <= edge_d;
      cfg_q       <= cfg_d;
      hist_q      <= din_sync;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign pad_dout  = out_q;
  assign pad_oen   = w_ready ? oen_q : '1;
  assign pad_ie    = w_pad_ie;
  assign pad_cfg   = cfg_q;
  assign irq       = |(evt_q & irqen_q);

  assign w_unused = ^{req_addr[1:0], req_wdata};

endmodule : asic_gpio_ctrl
`default_nettype wire
